// File: rtl/clkdiv_sched.sv
`default_nettype none
// ============================================================================
// Module   : clkdiv_sched
// Purpose  : Time-shares a single odd/even-capable clock divider among NREQ
//            requesters. A round-robin arbiter hands the divider to one
//            requester, which gets PERIODS full divided periods at its own
//            ratio, followed by a one-cycle gap and re-arbitration.
// Ports    : clk    - system clock
//            rst_n  - asynchronous active-low reset
//            req    - level request per requester
//            div_n  - divide ratio of requester i in [i*WIDTH +: WIDTH]
//            grant  - one-hot owner, zero when idle or in the gap
//            clkout - divided clock for the owner, 0 outside RUN
//            tick   - pulse in the last clk cycle of each divided period
//            done   - pulse in the cycle after a grant ends
//            busy   - high while a grant is running
// Revision : 1.0  initial release
// ============================================================================
module clkdiv_sched #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 24,
  parameter int PERIODS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] div_n,
  output logic [NREQ-1:0]       grant,
  output logic                  clkout,
  output logic                  tick,
  output logic                  done,
  output logic                  busy
);

  localparam int         PW         = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [7:0] C_LAST_PER = 8'(PERIODS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t           r_state;
  logic [PW-1:0]    r_ptr;
  logic [PW-1:0]    r_owner;
  logic [NREQ-1:0]  r_grant;
  logic [WIDTH-1:0] r_n;
  logic [WIDTH-1:0] r_cnt;
  logic [7:0]       r_per;
  logic             r_done;
  logic             r_busy;
  logic             r_clk_p;
  logic             r_clk_n;
  logic             r_run_en;

  logic [2*NREQ-1:0] w_dbl;
  logic [NREQ-1:0]   w_rot;
  logic              w_found;
  logic [PW-1:0]     w_winner;
  logic [PW-1:0]     w_next_ptr;
  logic [WIDTH-1:0]  w_div_sel;
  logic [WIDTH-1:0]  w_n_load;
  logic [WIDTH-1:0]  w_cnt_inc;
  logic [WIDTH-1:0]  w_half;
  logic              w_last;
  logic              w_end;
  logic              w_run_next;

  // Rotate requests so bit 0 is the current highest-priority requester, then
  // pick the lowest set bit (scan downward so the last hit wins).
  always_comb begin
    w_dbl    = {req, req} >> r_ptr;
    w_rot    = w_dbl[NREQ-1:0];
    w_found  = |w_rot;
    w_winner = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_winner = PW'((int'(r_ptr) + k) % NREQ);
      end
    end
  end

  always_comb begin
    w_div_sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_winner == PW'(k)) begin
        w_div_sel = div_n[k*WIDTH +: WIDTH];
      end
    end
  end

  // A ratio of 0 behaves as 1.
  assign w_n_load   = (w_div_sel == '0) ? WIDTH'(1) : w_div_sel;
  assign w_next_ptr = (w_winner == PW'(NREQ - 1)) ? '0 : w_winner + 1'b1;
  assign w_cnt_inc  = r_cnt + 1'b1;
  assign w_half     = r_n >> 1;
  assign w_last     = (r_cnt == r_n - 1'b1);
  assign w_end      = (r_state == S_RUN) && w_last &&
                      ((r_per == C_LAST_PER) || !req[r_owner]);
  // Whether the next clk cycle will be a RUN cycle; drives the N==1 gate.
  // Inputs are expected to be settled by the falling edge.
  assign w_run_next = ((r_state == S_IDLE) && w_found) ||
                      ((r_state == S_RUN) && !w_end);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_grant <= '0;
      r_n     <= '0;
      r_cnt   <= '0;
      r_per   <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_clk_p <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state <= S_RUN;
            r_grant <= NREQ'(1) << w_winner;
            r_owner <= w_winner;
            r_ptr   <= w_next_ptr;
            r_n     <= w_n_load;
            r_cnt   <= '0;
            r_per   <= '0;
            r_clk_p <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_last) begin
            r_cnt   <= '0;
            r_per   <= r_per + 1'b1;
            r_clk_p <= 1'b0;
            if (w_end) begin
              r_state <= S_GAP;
              r_grant <= '0;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt   <= w_cnt_inc;
            // clk_p tracks the count it will accompany: high for cnt >= N/2
            r_clk_p <= (w_cnt_inc >= w_half);
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Half-cycle delayed copy of clk_p (odd ratios) and the N==1 clock enable.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_n  <= 1'b0;
      r_run_en <= 1'b0;
    end else begin
      r_clk_n  <= r_clk_p;
      r_run_en <= w_run_next;
    end
  end

  // Odd ratios: ANDing with the half-cycle delayed copy trims half a clk
  // off the high phase, giving an exact 50% duty cycle.
  always_comb begin
    if (r_n == WIDTH'(1)) begin
      clkout = clk & r_run_en;
    end else if (r_n[0]) begin
      clkout = r_clk_p & r_clk_n;
    end else begin
      clkout = r_clk_p;
    end
  end

  assign tick  = (r_state == S_RUN) && w_last;
  assign grant = r_grant;
  assign done  = r_done;
  assign busy  = r_busy;

endmodule
`default_nettype wire
